div_ctrl: RTL and testbench

Multi-cycle signed divider controller for the lab4 ALU. It accepts one operand pair per start pulse and runs a restoring shift-subtract sequence, one quotient bit per clock. It returns quotient and remainder with the same semantics as the ALU's combinational `/` and `%`: truncation toward zero, and the remainder takes the sign of the dividend. It sits beside the ALU result mux and frees the critical path from the combinational divider.

---
 rtl/div_pkg.sv | 18 +
 rtl/div_step.sv | 27 ++
 rtl/div_ctrl.sv | 131 +++++++++++++
 tb/tb_div_ctrl.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types and constants for the multi-cycle signed divider.
// Used by the divider controller and its per-cycle step.
package div_pkg;

  localparam int DIV_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } state_t;

  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract step of the divider.
// Produces the next partial remainder and one quotient bit.
module div_step
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH:0]   rem,
  input  logic             din,
  input  logic [WIDTH-1:0] dsor,
  output logic [WIDTH:0]   rem_next,
  output logic             qbit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // rem < dsor always holds, so the shifted value fits and
  // the top bit of diff is a clean borrow flag.
  always_comb begin
    shifted  = {rem[WIDTH-1:0], din};
    diff     = shifted - {1'b0, dsor};
    qbit     = ~diff[WIDTH];
    rem_next = qbit ? diff : shifted;
  end

endmodule

// File: rtl/div_ctrl.sv
// Multi-cycle signed divider: restoring algorithm, one bit per clock,
// truncating quotient and dividend-signed remainder.
module div_ctrl
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_first_op,
  input  logic [WIDTH-1:0] i_second_op,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_data_div,
  output logic [WIDTH-1:0] o_data_rem,
  output logic             o_div_by_zero
);

  localparam int CW = cnt_width(WIDTH);

  state_t state;
  state_t state_nx;

  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH:0]   r;
  logic [WIDTH:0]   r_step;
  logic             q_bit;
  logic             sign_q;
  logic             sign_r;
  logic             dz;

  logic [WIDTH-1:0] a_abs;
  logic [WIDTH-1:0] b_abs;
  logic             b_zero;

  always_comb begin
    a_abs  = i_first_op;
    b_abs  = i_second_op;
    b_zero = (i_second_op == '0);
    if (i_first_op[WIDTH-1]) a_abs = -i_first_op;
    if (i_second_op[WIDTH-1]) b_abs = -i_second_op;
  end

  div_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .rem     (r),
    .din     (q[WIDTH-1]),
    .dsor    (b_mag),
    .rem_next(r_step),
    .qbit    (q_bit)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (i_start) state_nx = b_zero ? DONE : CALC;
      end
      CALC: begin
        if (cnt == CW'(1)) state_nx = FIX;
      end
      FIX:     state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt           <= '0;
      q             <= '0;
      r             <= '0;
      b_mag         <= '0;
      sign_q        <= 1'b0;
      sign_r        <= 1'b0;
      dz            <= 1'b0;
      o_busy        <= 1'b0;
      o_done        <= 1'b0;
      o_data_div    <= '0;
      o_data_rem    <= '0;
      o_div_by_zero <= 1'b0;
    end else begin
      // busy also covers the cycle in which o_done is shown
      o_busy <= (state_nx != IDLE) || (state == DONE);
      o_done <= (state == DONE);
      unique case (state)
        IDLE: begin
          if (i_start) begin
            sign_q <= i_first_op[WIDTH-1] ^ i_second_op[WIDTH-1];
            sign_r <= i_first_op[WIDTH-1];
            b_mag  <= b_abs;
            cnt    <= CW'(WIDTH);
            dz     <= b_zero;
            if (b_zero) begin
              q <= '1;
              r <= {1'b0, i_first_op};
            end else begin
              q <= a_abs;
              r <= '0;
            end
          end
        end
        CALC: begin
          q   <= {q[WIDTH-2:0], q_bit};
          r   <= r_step;
          cnt <= cnt - CW'(1);
        end
        FIX: begin
          if (sign_q) q <= -q;
          if (sign_r) r <= {1'b0, -r[WIDTH-1:0]};
        end
        DONE: begin
          o_data_div    <= q;
          o_data_rem    <= r[WIDTH-1:0];
          o_div_by_zero <= dz;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_ctrl.sv
// Directed and randomised checks of div_ctrl at WIDTH=32.
// Expected values come from hand arithmetic or a signed reference.
module tb_div_ctrl;

  localparam int W = 32;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] first_op;
  logic [W-1:0] second_op;
  logic         busy;
  logic         done;
  logic [W-1:0] data_div;
  logic [W-1:0] data_rem;
  logic         dbz;

  int checks;
  int errors;

  div_ctrl #(
    .WIDTH(W)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_start      (start),
    .i_first_op   (first_op),
    .i_second_op  (second_op),
    .o_busy       (busy),
    .o_done       (done),
    .o_data_div   (data_div),
    .o_data_rem   (data_rem),
    .o_div_by_zero(dbz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void model(input  logic [W-1:0] a,
                                input  logic [W-1:0] b,
                                output logic [W-1:0] q,
                                output logic [W-1:0] r,
                                output logic         z);
    logic signed [W-1:0] sa;
    logic signed [W-1:0] sb;
    sa = a;
    sb = b;
    z  = 1'b0;
    if (b == '0) begin
      q = '1;
      r = a;
      z = 1'b1;
    end else if (a == 32'h8000_0000 && b == 32'hffff_ffff) begin
      q = a;
      r = '0;
    end else begin
      q = sa / sb;
      r = sa % sb;
    end
  endfunction

  task automatic run_op(input logic [W-1:0] a,
                        input logic [W-1:0] b,
                        input logic [W-1:0] eq,
                        input logic [W-1:0] er,
                        input logic         ez,
                        input bit           inject,
                        input string        tag);
    int n;
    int lat;
    logic [W-1:0] prev_q;
    lat = (b == '0) ? 1 : W + 2;
    @(negedge clk);
    start     = 1'b1;
    first_op  = a;
    second_op = b;
    @(negedge clk);
    start  = 1'b0;
    prev_q = data_div;
    n      = 0;
    while (!done && n < 60) begin
      @(negedge clk);
      n++;
      start = 1'b0;
      if (inject && (n == 3 || n == 20)) begin
        start     = 1'b1;
        first_op  = 32'd999;
        second_op = 32'd4;
      end
      if (n == 10 && b != '0)
        chk({tag, "_hold"}, 64'(data_div), 64'(prev_q));
    end
    chk({tag, "_lat"}, 64'(n), 64'(lat));
    chk({tag, "_q"}, 64'(data_div), 64'(eq));
    chk({tag, "_r"}, 64'(data_rem), 64'(er));
    chk({tag, "_dz"}, 64'(dbz), 64'(ez));
    chk({tag, "_busy"}, 64'(busy), 64'd1);
    @(negedge clk);
    chk({tag, "_done_off"}, 64'(done), 64'd0);
    chk({tag, "_busy_off"}, 64'(busy), 64'd0);
  endtask

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic [W-1:0] mq;
    logic [W-1:0] mr;
    logic         mz;
    logic [W-1:0] corners [6];
    int dcount;
    int consec;
    int last;
    int gap_bad;
    int n;

    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    start     = 1'b0;
    first_op  = '0;
    second_op = '0;
    corners   = '{32'h8000_0000, 32'h7fff_ffff, 32'd1,
                  32'hffff_ffff, 32'd0, 32'd7};

    repeat (2) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_dz", 64'(dbz), 64'd0);
    chk("rst_q", 64'(data_div), 64'd0);
    chk("rst_r", 64'(data_rem), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 0, "p_p");
    run_op(-32'sd100, 32'd7, -32'sd14, -32'sd2, 1'b0, 0, "n_p");
    run_op(32'd100, -32'sd7, -32'sd14, 32'd2, 1'b0, 0, "p_n");
    run_op(-32'sd100, -32'sd7, 32'd14, -32'sd2, 1'b0, 0, "n_n");
    run_op(32'd5, 32'd0, 32'hffff_ffff, 32'd5, 1'b1, 0, "dz");
    run_op(32'h8000_0000, 32'hffff_ffff, 32'h8000_0000, 32'd0,
           1'b0, 0, "ovf");
    run_op(32'd1000, 32'd9, 32'd111, 32'd1, 1'b0, 1, "inj");

    // start held high: back-to-back accepts
    dcount  = 0;
    consec  = 0;
    gap_bad = 0;
    last    = -1;
    @(negedge clk);
    start     = 1'b1;
    first_op  = 32'd50;
    second_op = 32'd5;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (done) begin
        if (last == i - 2) consec++;
        if (last >= 0 && i - 1 - last != W + 3) gap_bad++;
        if (dcount == 0) chk("held_first", 64'(i - 1), 64'(W + 2));
        chk("held_q", 64'(data_div), 64'd10);
        last = i - 1;
        dcount++;
      end
    end
    start = 1'b0;
    chk("held_count", 64'(dcount), 64'd2);
    chk("held_consec", 64'(consec), 64'd0);
    chk("held_gap", 64'(gap_bad), 64'd0);
    n = 0;
    while (!done && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("held_tail", 64'(done), 64'd1);
    @(negedge clk);

    // reset in the middle of CALC
    start     = 1'b1;
    first_op  = 32'd1000;
    second_op = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_q", 64'(data_div), 64'd0);
    chk("abort_r", 64'(data_rem), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    dcount = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) dcount++;
    end
    chk("abort_nodone", 64'(dcount), 64'd0);
    run_op(32'd7, 32'd2, 32'd3, 32'd1, 1'b0, 0, "after_rst");

    for (int i = 0; i < 1000; i++) begin
      ra = ($urandom_range(0, 3) == 0) ?
           corners[$urandom_range(0, 5)] : W'($urandom);
      rb = ($urandom_range(0, 3) == 0) ?
           corners[$urandom_range(0, 5)] : W'($urandom);
      if ($urandom_range(0, 3) == 0) rb = W'($signed(rb) >>> 20);
      model(ra, rb, mq, mr, mz);
      run_op(ra, rb, mq, mr, mz, 0, "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
